// File: rtl/sram_rw_arbiter_if.sv
// ============================================================================
// Module : sram_rw_arbiter_if
// Brief  : Requester command/response channel for sram_rw_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_rw_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [NUM_WMASKS-1:0] wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, wmask, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, wmask, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_rw_arbiter.sv
// ============================================================================
// Module : sram_rw_arbiter
// Brief  : Round-robin two-requester sequencer for SRAM port 0, optional zero-fill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_rw_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_rw_arbiter_if.slave      m0,
  sram_rw_arbiter_if.slave      m1,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_ZERO ? ST_INIT : ST_ARB;
  localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic                  r_ptr;
  logic                  r_rd_pend;
  logic                  r_rd_own;
  logic                  r_init_done;
  logic [ADDR_WIDTH-1:0] r_addr_last;
  logic [DATA_WIDTH-1:0] r_din_last;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_sweep_last;

  assign w_sweep_last = &r_sweep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RESET;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && w_sweep_last) w_state_nxt = ST_ARB;
  end

  // Outputs are gated by rst so they fall back to idle as soon as reset asserts.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = r_addr_last;
    sram_din0   = r_din_last;
    if (!rst) begin
      case (r_state)
        ST_INIT: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = r_sweep;
          sram_din0   = '0;
        end
        default: begin
          w_gnt0 = m0.valid & (~m1.valid | ~r_ptr);
          w_gnt1 = m1.valid & (~m0.valid |  r_ptr);
          if (w_gnt0) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~m0.we;
            sram_wmask0 = m0.we ? m0.wmask : '0;
            sram_addr0  = m0.addr;
            sram_din0   = m0.wdata;
          end else if (w_gnt1) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~m1.we;
            sram_wmask0 = m1.we ? m1.wmask : '0;
            sram_addr0  = m1.addr;
            sram_din0   = m1.wdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep     <= '0;
      r_ptr       <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_own    <= 1'b0;
      r_init_done <= ~INIT_ZERO;
      r_addr_last <= '0;
      r_din_last  <= '0;
    end else begin
      if (r_state == ST_INIT) r_sweep <= r_sweep + c_ONE;
      if (r_state == ST_INIT && w_sweep_last) r_init_done <= 1'b1;
      if (!sram_csb0) begin
        r_addr_last <= sram_addr0;
        r_din_last  <= sram_din0;
      end
      if (w_gnt0)      r_ptr <= 1'b1;
      else if (w_gnt1) r_ptr <= 1'b0;
      r_rd_pend <= (w_gnt0 & ~m0.we) | (w_gnt1 & ~m1.we);
      if (w_gnt0 | w_gnt1) r_rd_own <= w_gnt1;
    end
  end

  assign m0.ready  = w_gnt0;
  assign m1.ready  = w_gnt1;
  assign m0.rvalid = r_rd_pend & ~r_rd_own;
  assign m1.rvalid = r_rd_pend &  r_rd_own;
  assign m0.rdata  = m0.rvalid ? sram_dout0 : '0;
  assign m1.rdata  = m1.rvalid ? sram_dout0 : '0;
  assign init_done = r_init_done;

endmodule

`default_nettype wire
